// File: rtl/mem_lsu.sv
// mem_lsu: memory-stage load/store unit. Issues one SRAM-like bus transaction per
// MEM instruction, aligns and extends load data, and stalls while a transfer is open.
module mem_lsu #(
  parameter int unsigned ADDR_W      = 32,
  parameter logic [31:0] RESET_RDATA = 32'h0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              refresh,
  input  logic              mem_adv,
  input  logic              mem_ex_any,
  input  logic              mem_data_en,
  input  logic [3:0]        mem_data_ren,
  input  logic [3:0]        mem_data_wen,
  input  logic [31:0]       mem_res,
  input  logic [31:0]       mem_wdata,
  input  logic              mem_loadX,
  input  logic [3:0]        mem_loadV,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [3:0]        data_wstrb,
  output logic [31:0]       data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [31:0]       data_rdata,
  output logic [31:0]       lsu_rdata,
  output logic              lsu_done,
  output logic              lsu_stall
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              r_state;
  logic                r_cancel;
  logic [31:0]         r_rdata;

  logic                r_wr;
  logic [1:0]          r_size;
  logic [ADDR_W-1:0]   r_addr;
  logic [3:0]          r_wstrb;
  logic [31:0]         r_wdata;
  logic                r_loadx;
  logic [3:0]          r_loadv;

  logic                w_access;
  logic [3:0]          w_lanes;
  logic                w_wr;
  logic [1:0]          w_size;
  logic [ADDR_W-1:0]   w_addr;
  logic [1:0]          w_lane;
  logic [31:0]         w_shifted;
  logic [31:0]         w_load_data;

  assign w_lanes  = mem_data_ren | mem_data_wen;
  assign w_access = mem_data_en & (|w_lanes) & ~mem_ex_any & ~refresh;
  assign w_wr     = |mem_data_wen;
  assign w_addr   = ADDR_W'(mem_res);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_size = 2'd2;
    case ($countones(w_lanes))
      1:       w_size = 2'd0;
      2:       w_size = 2'd1;
      default: w_size = 2'd2;
    endcase
  end

  // Start lane is the lowest valid load lane; width comes from the lane count.
  always_comb begin
    w_lane = 2'd0;
    if (r_loadv[0])      w_lane = 2'd0;
    else if (r_loadv[1]) w_lane = 2'd1;
    else if (r_loadv[2]) w_lane = 2'd2;
    else if (r_loadv[3]) w_lane = 2'd3;
    w_shifted   = data_rdata >> {w_lane, 3'b000};
    w_load_data = w_shifted;
    case ($countones(r_loadv))
      1: w_load_data = r_loadx ? {{24{w_shifted[7]}}, w_shifted[7:0]}
                               : {24'h0, w_shifted[7:0]};
      2: w_load_data = r_loadx ? {{16{w_shifted[15]}}, w_shifted[15:0]}
                               : {16'h0, w_shifted[15:0]};
      default: w_load_data = w_shifted;
    endcase
  end

  // IDLE presents the live request; ADDR replays the latched one until accepted.
  always_comb begin
    data_wr    = w_wr;
    data_size  = w_size;
    data_addr  = w_addr;
    data_wstrb = mem_data_wen;
    data_wdata = mem_wdata;
    if (r_state == S_ADDR) begin
      data_wr    = r_wr;
      data_size  = r_size;
      data_addr  = r_addr;
      data_wstrb = r_wstrb;
      data_wdata = r_wdata;
    end
    data_req = resetn & (((r_state == S_IDLE) & w_access) | (r_state == S_ADDR));
  end

  assign lsu_stall = ((r_state == S_IDLE) & w_access) | (r_state == S_ADDR) | (r_state == S_DATA);
  assign lsu_done  = (r_state == S_DONE);
  assign lsu_rdata = r_rdata;

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_cancel <= 1'b0;
      r_rdata  <= RESET_RDATA;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_access) r_state <= data_addr_ok ? S_DATA : S_ADDR;
        end
        S_ADDR: begin
          if (refresh)      r_cancel <= 1'b1;
          if (data_addr_ok) r_state  <= S_DATA;
        end
        S_DATA: begin
          if (data_data_ok) begin
            r_cancel <= 1'b0;
            if (r_cancel || refresh) begin
              r_state <= S_IDLE;
            end else begin
              r_state <= S_DONE;
              if (!r_wr) r_rdata <= w_load_data;
            end
          end else if (refresh) begin
            r_cancel <= 1'b1;
          end
        end
        S_DONE: begin
          if (refresh) begin
            r_state <= S_IDLE;
            r_rdata <= RESET_RDATA;
          end else if (mem_adv) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: request-field registers carry no reset; they are loaded on issue and only read afterwards.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && w_access) begin
      r_wr    <= w_wr;
      r_size  <= w_size;
      r_addr  <= w_addr;
      r_wstrb <= mem_data_wen;
      r_wdata <= mem_wdata;
      r_loadx <= mem_loadX;
      r_loadv <= mem_loadV;
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Randomized bench for mem_lsu: a pipeline driver and bus slave stimulate the DUT,
// and a transaction-level model predicts bus, stall, done and load results every cycle.
module tb_mem_lsu;

  localparam logic [31:0] RESET_RDATA = 32'h0;
  localparam int          NCYC        = 4000;

  logic        clk = 1'b0;
  logic        resetn, refresh, mem_adv, mem_ex_any, mem_data_en, mem_loadX;
  logic [3:0]  mem_data_ren, mem_data_wen, mem_loadV;
  logic [31:0] mem_res, mem_wdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata, lsu_rdata;
  logic [3:0]  data_wstrb;
  logic        lsu_done, lsu_stall;

  always #5 clk = ~clk;

  mem_lsu #(.ADDR_W(32), .RESET_RDATA(RESET_RDATA)) dut (
    .clk(clk), .resetn(resetn), .refresh(refresh), .mem_adv(mem_adv),
    .mem_ex_any(mem_ex_any), .mem_data_en(mem_data_en),
    .mem_data_ren(mem_data_ren), .mem_data_wen(mem_data_wen),
    .mem_res(mem_res), .mem_wdata(mem_wdata), .mem_loadX(mem_loadX),
    .mem_loadV(mem_loadV), .data_req(data_req), .data_wr(data_wr),
    .data_size(data_size), .data_addr(data_addr), .data_wstrb(data_wstrb),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .lsu_rdata(lsu_rdata), .lsu_done(lsu_done), .lsu_stall(lsu_stall)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic        en;
    logic        ex;
    logic [3:0]  ren;
    logic [3:0]  wen;
    logic [3:0]  loadv;
    logic        loadx;
    logic [31:0] res;
    logic [31:0] wdata;
  } instr_t;

  function automatic instr_t new_instr();
    instr_t     t;
    int         kind, sz;
    logic [3:0] mask;
    logic [1:0] lane;
    t.en    = 1'b1;
    t.ex    = 1'b0;
    t.ren   = 4'h0;
    t.wen   = 4'h0;
    t.loadv = 4'h0;
    t.loadx = 1'($urandom_range(0, 1));
    t.res   = $urandom;
    t.wdata = $urandom;
    kind    = int'($urandom_range(0, 9));
    sz      = int'($urandom_range(0, 2));
    mask    = (sz == 0) ? 4'b0001 : (sz == 1) ? 4'b0011 : 4'b1111;
    lane    = (sz == 0) ? 2'($urandom_range(0, 3)) :
              (sz == 1) ? 2'($urandom_range(0, 1) * 2) : 2'd0;
    mask    = mask << lane;
    t.res[1:0] = lane;
    case (kind)
      0:          begin t.en = 1'b0; t.ren = mask; end
      1:          begin t.ex = 1'b1; t.ren = mask; end
      2:          ;
      3, 4, 5, 6: begin t.ren = mask; t.loadv = mask; end
      default:    t.wen = mask;
    endcase
    return t;
  endfunction

  function automatic logic [1:0] size_of(input logic [3:0] lanes);
    int n;
    n = $countones(lanes);
    return (n == 1) ? 2'd0 : (n == 2) ? 2'd1 : 2'd2;
  endfunction

  // Gather the valid bytes starting at the lowest lane, then extend.
  function automatic logic [31:0] align_load(input logic [31:0] rd, input logic [3:0] v,
                                             input logic sx);
    int          n, start;
    logic [31:0] val;
    n     = $countones(v);
    start = 0;
    while (start < 4 && !v[start]) start++;
    val = 32'h0;
    for (int i = 0; i < n; i++) val[8*i +: 8] = rd[8*(start+i) +: 8];
    if (sx && n > 0 && val[8*n-1])
      for (int b = 8 * n; b < 32; b++) val[b] = 1'b1;
    return val;
  endfunction

  // Model: request waiting for acceptance, response outstanding, response to be
  // dropped because of a flush, result delivered and awaiting advance.
  logic        m_hold, m_wait, m_flush, m_done;
  logic [31:0] m_rdata;
  logic        t_wr, t_loadx;
  logic [1:0]  t_size;
  logic [31:0] t_addr, t_wdata;
  logic [3:0]  t_wstrb, t_loadv;

  instr_t      cur;
  logic        need_new;
  int          slave_cnt;
  logic        access, idle, exp_req, exp_stall, accepted;
  logic        e_wr;
  logic [1:0]  e_size;
  logic [31:0] e_addr, e_wdata;
  logic [3:0]  e_wstrb;

  initial begin
    resetn = 1'b0; refresh = 1'b0; mem_adv = 1'b0; mem_ex_any = 1'b0;
    mem_data_en = 1'b0; mem_data_ren = 4'h0; mem_data_wen = 4'h0;
    mem_res = 32'h0; mem_wdata = 32'h0; mem_loadX = 1'b0; mem_loadV = 4'h0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
    m_hold = 1'b0; m_wait = 1'b0; m_flush = 1'b0; m_done = 1'b0;
    m_rdata = RESET_RDATA; need_new = 1'b1; slave_cnt = 0;
    t_wr = 1'b0; t_loadx = 1'b0; t_size = 2'd0; t_addr = 32'h0;
    t_wdata = 32'h0; t_wstrb = 4'h0; t_loadv = 4'h0;
    @(posedge clk);
    #1;
    for (int c = 0; c < NCYC; c++) begin
      resetn = !(c < 2 || $urandom_range(0, 199) == 0);
      if (need_new) begin
        cur      = new_instr();
        need_new = 1'b0;
      end
      if (m_hold) begin
        // Inputs wander while the latched request waits for acceptance.
        mem_data_en  = 1'($urandom_range(0, 1));
        mem_ex_any   = 1'($urandom_range(0, 1));
        mem_data_ren = 4'($urandom);
        mem_data_wen = 4'($urandom);
        mem_loadV    = 4'($urandom);
        mem_loadX    = 1'($urandom_range(0, 1));
        mem_res      = $urandom;
        mem_wdata    = $urandom;
      end else begin
        mem_data_en  = cur.en;
        mem_ex_any   = cur.ex;
        mem_data_ren = cur.ren;
        mem_data_wen = cur.wen;
        mem_loadV    = cur.loadv;
        mem_loadX    = cur.loadx;
        mem_res      = cur.res;
        mem_wdata    = cur.wdata;
      end
      data_data_ok = (slave_cnt == 1);
      data_addr_ok = ($urandom_range(0, 2) == 0);
      data_rdata   = $urandom;
      refresh      = resetn && !data_data_ok && ($urandom_range(0, 24) == 0);

      access    = mem_data_en && ((mem_data_ren | mem_data_wen) != 4'h0) && !mem_ex_any && !refresh;
      idle      = !m_hold && !m_wait && !m_done;
      exp_req   = resetn && (m_hold || (idle && access));
      exp_stall = (idle && access) || m_hold || m_wait;
      mem_adv   = !exp_stall && !refresh && ($urandom_range(0, 2) != 0);

      if (m_hold) begin
        e_wr = t_wr; e_size = t_size; e_addr = t_addr; e_wstrb = t_wstrb; e_wdata = t_wdata;
      end else begin
        e_wr    = (mem_data_wen != 4'h0);
        e_size  = size_of(mem_data_ren | mem_data_wen);
        e_addr  = mem_res;
        e_wstrb = mem_data_wen;
        e_wdata = mem_wdata;
      end

      #4;
      check("data_req", 32'(data_req), 32'(exp_req));
      if (exp_req) begin
        check("data_wr", 32'(data_wr), 32'(e_wr));
        check("data_size", 32'(data_size), 32'(e_size));
        check("data_addr", data_addr, e_addr);
        check("data_wstrb", 32'(data_wstrb), 32'(e_wstrb));
        if (e_wr) check("data_wdata", data_wdata, e_wdata);
      end
      if (resetn) begin
        check("lsu_stall", 32'(lsu_stall), 32'(exp_stall));
        check("lsu_done", 32'(lsu_done), 32'(m_done));
        check("lsu_rdata", lsu_rdata, m_rdata);
      end

      if (!resetn) begin
        m_hold = 1'b0; m_wait = 1'b0; m_flush = 1'b0; m_done = 1'b0;
        m_rdata = RESET_RDATA; slave_cnt = 0; need_new = 1'b1;
      end else begin
        accepted = exp_req && data_addr_ok;
        if (m_done) begin
          if (refresh) begin
            m_done  = 1'b0;
            m_rdata = RESET_RDATA;
          end else if (mem_adv) begin
            m_done = 1'b0;
          end
        end else if (m_wait) begin
          if (refresh) m_flush = 1'b1;
          if (data_data_ok) begin
            m_wait = 1'b0;
            if (m_flush) begin
              m_flush = 1'b0;
            end else begin
              if (!t_wr) m_rdata = align_load(data_rdata, t_loadv, t_loadx);
              m_done = 1'b1;
            end
          end
        end else if (m_hold) begin
          if (refresh) m_flush = 1'b1;
          if (data_addr_ok) begin
            m_hold = 1'b0;
            m_wait = 1'b1;
          end
        end else if (access) begin
          t_wr = e_wr; t_size = e_size; t_addr = e_addr; t_wstrb = e_wstrb; t_wdata = e_wdata;
          t_loadv = mem_loadV; t_loadx = mem_loadX;
          if (data_addr_ok) m_wait = 1'b1;
          else              m_hold = 1'b1;
        end
        if (slave_cnt > 0) slave_cnt--;
        if (accepted) slave_cnt = int'($urandom_range(1, 3));
        need_new = refresh || mem_adv;
      end

      @(posedge clk);
      #1;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
